// File: rtl/servo_pwm_generator.sv
// -----------------------------------------------------------------------------
// servo_pwm_generator
//
// Dual-channel hobby-servo pulse generator. It takes the 7-bit X/Y position
// codes from the servo-select stage and emits two frame-locked servo pulse
// trains. The pulse high time is MIN_US + code*STEP_US microseconds, clamped
// to MAX_US. Codes are adopted only at frame boundaries, so a pulse that is
// already in progress is never truncated or stretched.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   enable       in   level; run pulse generation (current frame always completes)
//   x_code[6:0]  in   X position code (asynchronous to frames, may change anytime)
//   y_code[6:0]  in   Y position code
//   x_servo      out  X servo pulse (registered)
//   y_servo      out  Y servo pulse (registered)
//   frame_start  out  one-cycle strobe on the first cycle of each frame
//   x_active     out  X code in use for the current frame
//   y_active     out  Y code in use for the current frame
//
// Build option:
//   SERVO_PWM_SLEW_EN  when defined, the active code moves toward a new stable
//                      code by at most SLEW_STEP codes per frame. When
//                      undefined, a stable code is adopted directly and the
//                      SLEW_STEP parameter does not exist.
// -----------------------------------------------------------------------------
module servo_pwm_generator #(
    parameter int unsigned TICKS_PER_US = 50,
    parameter int unsigned FRAME_US     = 20000,
    parameter int unsigned MIN_US       = 1000,
    parameter int unsigned STEP_US      = 8,
    parameter int unsigned MAX_US       = 2000
`ifdef SERVO_PWM_SLEW_EN
    ,
    parameter int unsigned SLEW_STEP    = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] x_code,
    input  logic [6:0] y_code,
    output logic       x_servo,
    output logic       y_servo,
    output logic       frame_start,
    output logic [6:0] x_active,
    output logic [6:0] y_active
);

    localparam int unsigned CODE_W  = 7;
    localparam int unsigned WIDTH_W = 12;
    localparam int unsigned PRE_W   = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int unsigned US_W    = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int unsigned CMP_W   = (US_W > WIDTH_W) ? US_W : WIDTH_W;

    localparam logic [CODE_W-1:0]  CODE_CENTRE = CODE_W'(64);
    localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(TICKS_PER_US - 1);
    localparam logic [US_W-1:0]    US_LAST     = US_W'(FRAME_US - 1);
    localparam logic [WIDTH_W-1:0] WIDTH_MIN   = WIDTH_W'(MIN_US);
    localparam logic [WIDTH_W-1:0] WIDTH_STEP  = WIDTH_W'(STEP_US);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX   = WIDTH_W'(MAX_US);

`ifdef SERVO_PWM_SLEW_EN
    localparam int unsigned SLEW_W   = CODE_W + 1;
    localparam int unsigned SLEW_CAP = (SLEW_STEP > 127) ? 127 : SLEW_STEP;
    localparam logic [SLEW_W-1:0] SLEW_LIM = SLEW_W'(SLEW_CAP);
`endif

    // Frame sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Pulse width in microseconds, computed in 12 bits and clamped to MAX_US.
    function automatic logic [WIDTH_W-1:0] pulse_width(input logic [CODE_W-1:0] code);
        logic [WIDTH_W-1:0] raw;
        raw = WIDTH_MIN + (WIDTH_W'(code) * WIDTH_STEP);
        return (raw > WIDTH_MAX) ? WIDTH_MAX : raw;
    endfunction

`ifdef SERVO_PWM_SLEW_EN
    // Move cur toward tgt by at most SLEW_STEP; lands exactly on tgt, never past it.
    function automatic logic [CODE_W-1:0] slew_toward(input logic [CODE_W-1:0] cur,
                                                      input logic [CODE_W-1:0] tgt);
        logic [SLEW_W-1:0] diff;
        logic [CODE_W-1:0] res;
        res = tgt;
        if (tgt > cur) begin
            diff = SLEW_W'(tgt) - SLEW_W'(cur);
            if (diff > SLEW_LIM) begin
                res = CODE_W'(SLEW_W'(cur) + SLEW_LIM);
            end
        end else begin
            diff = SLEW_W'(cur) - SLEW_W'(tgt);
            if (diff > SLEW_LIM) begin
                res = CODE_W'(SLEW_W'(cur) - SLEW_LIM);
            end
        end
        return res;
    endfunction
`endif

    // Code adopted at a frame boundary; an unsettled input keeps the old code.
    function automatic logic [CODE_W-1:0] next_active(input logic [CODE_W-1:0] cur,
                                                      input logic [CODE_W-1:0] s1,
                                                      input logic [CODE_W-1:0] s2);
        logic [CODE_W-1:0] res;
        res = cur;
        if (s1 == s2) begin
`ifdef SERVO_PWM_SLEW_EN
            res = slew_toward(cur, s2);
`else
            res = s2;
`endif
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,       state_d;
    logic [PRE_W-1:0]  pre_q,         pre_d;
    logic [US_W-1:0]   us_q,          us_d;
    logic [CODE_W-1:0] x_act_q,       x_act_d;
    logic [CODE_W-1:0] y_act_q,       y_act_d;
    logic              x_servo_q,     x_servo_d;
    logic              y_servo_q,     y_servo_d;
    logic              frame_start_q, frame_start_d;

    logic [CODE_W-1:0] x_s1_q, x_s1_d;
    logic [CODE_W-1:0] x_s2_q, x_s2_d;
    logic [CODE_W-1:0] y_s1_q, y_s1_d;
    logic [CODE_W-1:0] y_s2_q, y_s2_d;

    logic us_tick_c;
    logic frame_end_c;

    // Input capture pipeline; free-running so it is already settled when reset lifts.
    always_ff @(posedge clk) begin
        x_s1_q <= x_s1_d;
        x_s2_q <= x_s2_d;
        y_s1_q <= y_s1_d;
        y_s2_q <= y_s2_d;
    end

    // Sequencer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pre_q         <= '0;
            us_q          <= '0;
            x_act_q       <= CODE_CENTRE;
            y_act_q       <= CODE_CENTRE;
            x_servo_q     <= 1'b0;
            y_servo_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            us_q          <= us_d;
            x_act_q       <= x_act_d;
            y_act_q       <= y_act_d;
            x_servo_q     <= x_servo_d;
            y_servo_q     <= y_servo_d;
            frame_start_q <= frame_start_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pre_d         = pre_q;
        us_d          = us_q;
        x_act_d       = x_act_q;
        y_act_d       = y_act_q;
        x_servo_d     = 1'b0;
        y_servo_d     = 1'b0;
        frame_start_d = 1'b0;

        x_s1_d = x_code;
        x_s2_d = x_s1_q;
        y_s1_d = y_code;
        y_s2_d = y_s1_q;

        us_tick_c   = (pre_q == PRE_LAST);
        frame_end_c = us_tick_c && (us_q == US_LAST);

        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                us_d  = '0;
                if (enable) begin
                    state_d = S_FRAME;
                end
            end

            S_FRAME: begin
                pre_d   = '0;
                us_d    = '0;
                x_act_d = next_active(x_act_q, x_s1_q, x_s2_q);
                y_act_d = next_active(y_act_q, y_s1_q, y_s2_q);
                state_d = S_RUN;
            end

            S_RUN: begin
                if (us_tick_c) begin
                    pre_d = '0;
                    if (frame_end_c) begin
                        // enable is only honoured here, so a frame always completes
                        us_d    = '0;
                        state_d = enable ? S_FRAME : S_IDLE;
                    end else begin
                        us_d = us_q + US_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end

            default: begin
                pre_d   = '0;
                us_d    = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed from next-cycle values so the flops line up
        // with the counters: high for exactly width_us * TICKS_PER_US cycles.
        frame_start_d = (state_d == S_FRAME);
        if (state_d == S_RUN) begin
            x_servo_d = (CMP_W'(us_d) < CMP_W'(pulse_width(x_act_d)));
            y_servo_d = (CMP_W'(us_d) < CMP_W'(pulse_width(y_act_d)));
        end
    end

    assign x_servo     = x_servo_q;
    assign y_servo     = y_servo_q;
    assign frame_start = frame_start_q;
    assign x_active    = x_act_q;
    assign y_active    = y_act_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// -----------------------------------------------------------------------------
// Self-checking bench for servo_pwm_generator, run with scaled-down timing
// parameters so that a frame is 401 cycles. Each frame is measured from one
// frame_start strobe to the next and compared against a frame-level model.
// -----------------------------------------------------------------------------
module tb_servo_pwm_generator;

    localparam int unsigned T    = 2;
    localparam int unsigned FUS  = 200;
    localparam int unsigned MINU = 20;
    localparam int unsigned STEP = 1;
    localparam int unsigned MAXU = 120;
    localparam int unsigned SLEW = 4;
    localparam int PERIOD = FUS * T + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] x_code = 7'd0;
    logic [6:0] y_code = 7'd0;
    logic       x_servo, y_servo, frame_start;
    logic [6:0] x_active, y_active;

    int errors = 0;
    int checks = 0;
    int mx = 64, my = 64;   // model: active codes for the current frame
    int cx = 0, cy = 0;     // codes currently driven

    servo_pwm_generator #(
        .TICKS_PER_US(T),
        .FRAME_US    (FUS),
        .MIN_US      (MINU),
        .STEP_US     (STEP),
        .MAX_US      (MAXU)
`ifdef SERVO_PWM_SLEW_EN
        ,
        .SLEW_STEP   (SLEW)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .x_code     (x_code),
        .y_code     (y_code),
        .x_servo    (x_servo),
        .y_servo    (y_servo),
        .frame_start(frame_start),
        .x_active   (x_active),
        .y_active   (y_active)
    );

    always #5 clk = ~clk;

    // Expected high time in cycles for a code.
    function automatic int exp_high(input int c);
        int w;
        w = MINU + c * STEP;
        if (w > MAXU) w = MAXU;
        return w * T;
    endfunction

    // Code in use next frame, given the current code and a stable target.
    function automatic int model_next(input int cur, input int tgt);
`ifdef SERVO_PWM_SLEW_EN
        if (tgt > cur + SLEW) return cur + SLEW;
        if (tgt + SLEW < cur) return cur - SLEW;
        return tgt;
`else
        if (cur < 0) return cur;
        return tgt;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a frame_start strobe; returns cycles waited, -1 on timeout.
    task automatic wait_fs(output int cycles);
        cycles = -1;
        for (int i = 1; i <= PERIOD + 10; i++) begin
            step();
            if (frame_start === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Called on a frame_start cycle; measures the frame until the next strobe.
    // Optionally changes codes at cycle chg_at, or toggles x_code from tog_from on.
    task automatic measure(input int chg_at, input int nx, input int ny, input int tog_from,
                           output int period, output int xh, output int yh,
                           output int xa, output int ya);
        int n;
        n = 0; xh = 0; yh = 0; xa = -1; ya = -1;
        while (1) begin
            step();
            n++;
            if (x_servo === 1'b1) xh++;
            if (y_servo === 1'b1) yh++;
            if (n == 1) begin
                xa = int'(x_active);
                ya = int'(y_active);
            end
            if (n == chg_at) begin
                x_code = 7'(nx);
                y_code = 7'(ny);
            end
            if (tog_from > 0 && n >= tog_from) x_code = (n % 2 == 1) ? 7'd5 : 7'd90;
            if (frame_start === 1'b1 || n >= PERIOD + 20) break;
        end
        period = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        x_code = 7'd0; y_code = 7'd64; cx = 0; cy = 64;
        repeat (4) step();
        checks++; if (x_servo !== 1'b0) begin errors++; $display("FAIL reset_x_servo got %b expected 0", x_servo); end
        checks++; if (y_servo !== 1'b0) begin errors++; $display("FAIL reset_y_servo got %b expected 0", y_servo); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b expected 0", frame_start); end
        checks++; if (x_active !== 7'd64) begin errors++; $display("FAIL reset_x_active got %0d expected 64", x_active); end
        checks++; if (y_active !== 7'd64) begin errors++; $display("FAIL reset_y_active got %0d expected 64", y_active); end
        rst_n = 1'b1;
        mx = 64; my = 64;
        step();
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL idle_no_frame got %b expected 0", frame_start); end
    endtask

    task automatic test_basic();
        int lat, p, xh, yh, xa, ya;
        enable = 1'b1;
        wait_fs(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL start_latency got %0d expected 1", lat); end
        for (int f = 0; f < 2; f++) begin
            mx = model_next(mx, cx); my = model_next(my, cy);
            measure(0, 0, 0, 0, p, xh, yh, xa, ya);
            checks++; if (p !== PERIOD) begin errors++; $display("FAIL basic_period got %0d expected %0d", p, PERIOD); end
            checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL basic_x_high got %0d expected %0d", xh, exp_high(mx)); end
            checks++; if (yh !== exp_high(my)) begin errors++; $display("FAIL basic_y_high got %0d expected %0d", yh, exp_high(my)); end
            checks++; if (xa !== mx) begin errors++; $display("FAIL basic_x_active got %0d expected %0d", xa, mx); end
        end
    endtask

    task automatic test_clamp();
        int p, xh, yh, xa, ya;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(100, 127, 64, 0, p, xh, yh, xa, ya);
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL clamp_pre_x_high got %0d expected %0d", xh, exp_high(mx)); end
        cx = 127; cy = 64;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(0, 0, 0, 0, p, xh, yh, xa, ya);
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL clamp_x_high got %0d expected %0d", xh, exp_high(mx)); end
        checks++; if (yh !== exp_high(my)) begin errors++; $display("FAIL clamp_y_high got %0d expected %0d", yh, exp_high(my)); end
        checks++; if (xa !== mx) begin errors++; $display("FAIL clamp_x_active got %0d expected %0d", xa, mx); end
        checks++; if (p !== PERIOD) begin errors++; $display("FAIL clamp_period got %0d expected %0d", p, PERIOD); end
    endtask

    task automatic test_mid_change();
        int p, xh, yh, xa, ya;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(100, 20, cy, 0, p, xh, yh, xa, ya);
        cx = 20;
        mx = model_next(mx, cx); my = model_next(my, cy);
        // change lands in the middle of this frame's pulse
        measure(exp_high(mx) / 2, 90, cy, 0, p, xh, yh, xa, ya);
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL mid_frame_n_x_high got %0d expected %0d", xh, exp_high(mx)); end
        cx = 90;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(0, 0, 0, 0, p, xh, yh, xa, ya);
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL mid_frame_n1_x_high got %0d expected %0d", xh, exp_high(mx)); end
    endtask

    task automatic test_random();
        int p, xh, yh, xa, ya, nx, ny, chg;
        int fixed_codes[4] = '{100, 101, 0, 125};
        for (int f = 0; f < 10; f++) begin
            nx = (f < 4) ? fixed_codes[f] : int'($urandom_range(127));
            ny = int'($urandom_range(127));
            chg = int'($urandom_range(PERIOD - 10, 5));
            mx = model_next(mx, cx); my = model_next(my, cy);
            measure(chg, nx, ny, 0, p, xh, yh, xa, ya);
            checks++; if (p !== PERIOD) begin errors++; $display("FAIL rand_period got %0d expected %0d", p, PERIOD); end
            checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL rand_x_high got %0d expected %0d", xh, exp_high(mx)); end
            checks++; if (yh !== exp_high(my)) begin errors++; $display("FAIL rand_y_high got %0d expected %0d", yh, exp_high(my)); end
            checks++; if (xa !== mx || ya !== my) begin errors++; $display("FAIL rand_active got %0d/%0d expected %0d/%0d", xa, ya, mx, my); end
            cx = nx; cy = ny;
        end
    endtask

    task automatic test_toggle();
        int p, xh, yh, xa, ya;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(0, 0, 0, PERIOD - 8, p, xh, yh, xa, ya);
        // x unsettled at this boundary: x keeps its code, y updates normally
        my = model_next(my, cy);
        measure(2, 33, cy, 0, p, xh, yh, xa, ya);
        checks++; if (xa !== mx) begin errors++; $display("FAIL toggle_x_active_held got %0d expected %0d", xa, mx); end
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL toggle_x_high got %0d expected %0d", xh, exp_high(mx)); end
        cx = 33;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(0, 0, 0, 0, p, xh, yh, xa, ya);
        checks++; if (xa !== mx) begin errors++; $display("FAIL toggle_x_active_next got %0d expected %0d", xa, mx); end
    endtask

    task automatic test_enable_drop();
        int xh, bad, lat;
        xh = 0; bad = 0;
        mx = model_next(mx, cx); my = model_next(my, cy);
        for (int n = 1; n <= PERIOD; n++) begin
            step();
            if (x_servo === 1'b1) xh++;
            if (n == 10 * T) enable = 1'b0;
            if (n == PERIOD) begin
                checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL drop_frame_start got %b expected 0", frame_start); end
            end
        end
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL drop_full_pulse got %0d expected %0d", xh, exp_high(mx)); end
        for (int n = 0; n < 500; n++) begin
            step();
            if (frame_start !== 1'b0 || x_servo !== 1'b0 || y_servo !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL drop_idle_quiet got %0d active cycles expected 0", bad); end
        enable = 1'b1;
        wait_fs(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL restart_latency got %0d expected 1", lat); end
    endtask

    task automatic test_reset_mid_pulse();
        int lat, p, xh, yh, xa, ya;
        mx = model_next(mx, cx); my = model_next(my, cy);
        repeat (10) step();
        checks++; if (x_servo !== 1'b1) begin errors++; $display("FAIL pre_reset_x_servo got %b expected 1", x_servo); end
        rst_n = 1'b0;
        step();
        checks++; if (x_servo !== 1'b0 || y_servo !== 1'b0) begin errors++; $display("FAIL mid_reset_servo got %b%b expected 00", x_servo, y_servo); end
        checks++; if (x_active !== 7'd64 || y_active !== 7'd64) begin errors++; $display("FAIL mid_reset_active got %0d/%0d expected 64/64", x_active, y_active); end
        rst_n = 1'b1;
        mx = 64; my = 64;
        wait_fs(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL post_reset_latency got %0d expected 1", lat); end
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(0, 0, 0, 0, p, xh, yh, xa, ya);
        checks++; if (xh !== exp_high(mx)) begin errors++; $display("FAIL post_reset_x_high got %0d expected %0d", xh, exp_high(mx)); end
    endtask

    task automatic test_slew();
        int p, xh, yh, xa, ya;
        mx = model_next(mx, cx); my = model_next(my, cy);
        measure(5, 10, cy, 0, p, xh, yh, xa, ya);
        cx = 10;
        for (int k = 0; k < 40; k++) begin
            mx = model_next(mx, cx); my = model_next(my, cy);
            if (mx == 10) break;
            measure(0, 0, 0, 0, p, xh, yh, xa, ya);
        end
        measure(5, 100, cy, 0, p, xh, yh, xa, ya);
        checks++; if (xa !== 10) begin errors++; $display("FAIL slew_start got %0d expected 10", xa); end
        cx = 100;
        for (int f = 0; f < 23; f++) begin
            mx = model_next(mx, cx); my = model_next(my, cy);
            measure(0, 0, 0, 0, p, xh, yh, xa, ya);
            checks++; if (xa !== mx) begin errors++; $display("FAIL slew_x_active frame %0d got %0d expected %0d", f, xa, mx); end
        end
        checks++; if (xa !== 100) begin errors++; $display("FAIL slew_final got %0d expected 100", xa); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_mid_change();
        test_random();
        test_toggle();
        test_enable_drop();
        test_reset_mid_pulse();
        test_slew();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
